mem_access_unit: RTL and testbench

Registered MEM-stage controller between the EX/MEM pipeline buffer and the MEM/WB buffer. It accepts one instruction per cycle and passes ALU-only instructions through with one cycle of latency. For loads and stores it runs a req/ack handshake with a variable-latency data memory and stalls the upstream pipeline until the access completes. Its outputs feed the MEM/WB buffer's alu_result/memory_data/rsd/Op/valid inputs directly.

---
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: registered MEM-stage controller with req/ack data-memory handshake.
//   Pipeline in : alu_result_i (address for loads/stores), wdata_i, rsd_i, Op_i, valid_i,
//                 mem_read_i, mem_write_i
//   Pipeline out: stall_o, alu_result_o, memory_data_o, rsd_o, Op_o, valid_o, err_o
//   Memory side : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i
//   Optional    : MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES WAIT cycles without ack
//                 and sets the sticky err_o flag.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rsd_i,
    input  logic [2:0]  Op_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] alu_result_o,
    output logic [31:0] memory_data_o,
    output logic [4:0]  rsd_o,
    output logic [2:0]  Op_o,
    output logic        valid_o,
    output logic        err_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // empty block that only elaborates for a counter too narrow to reach the limit
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_bad
    end

    logic [0:0]  r_state;
    logic [31:0] r_addr, r_wdata, r_alu, r_mdata;
    logic [4:0]  r_rsd, r_rsd_out;
    logic [2:0]  r_op, r_op_out;
    logic        r_we, r_valid;
    logic        w_wait, w_memop, w_abort;

    assign w_wait      = (r_state == S_WAIT);
    assign w_memop     = mem_read_i | mem_write_i;
    assign stall_o     = w_wait;
    assign mem_req_o   = w_wait;
    assign mem_we_o    = w_wait & r_we;
    assign mem_addr_o  = w_wait ? r_addr : '0;
    assign mem_wdata_o = w_wait ? r_wdata : '0;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    // r_cnt counts completed ack-less WAIT cycles, so the limit is hit in the cycle holding LIMIT-1
    assign w_abort = w_wait & ~mem_ack_i & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (w_wait & ~mem_ack_i & ~w_abort) ? r_cnt + 1'b1 : '0;
            r_err <= r_err | w_abort;
        end
    end
`else
    assign w_abort = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rsd     <= '0;
            r_op      <= '0;
            r_we      <= 1'b0;
            r_alu     <= '0;
            r_mdata   <= '0;
            r_rsd_out <= '0;
            r_op_out  <= '0;
            r_valid   <= 1'b0;
        end else if (!w_wait) begin
            r_valid <= valid_i & ~w_memop;
            if (valid_i && !w_memop) begin
                r_alu     <= alu_result_i;
                r_mdata   <= '0;
                r_rsd_out <= rsd_i;
                r_op_out  <= Op_i;
            end
            if (valid_i && w_memop) begin
                r_addr  <= alu_result_i;
                r_wdata <= wdata_i;
                r_rsd   <= rsd_i;
                r_op    <= Op_i;
                r_we    <= mem_write_i;
                r_state <= S_WAIT;
            end
        end else if (mem_ack_i) begin
            r_alu     <= r_addr;
            r_mdata   <= r_we ? '0 : mem_rdata_i;
            r_rsd_out <= r_rsd;
            r_op_out  <= r_op;
            r_valid   <= 1'b1;
            r_state   <= S_IDLE;
        end else begin
            r_valid <= 1'b0;
            if (w_abort) r_state <= S_IDLE;
        end
    end

    assign alu_result_o  = r_alu;
    assign memory_data_o = r_mdata;
    assign rsd_o         = r_rsd_out;
    assign Op_o          = r_op_out;
    assign valid_o       = r_valid;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit.
module tb_mem_access_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] alu_result_i = '0, wdata_i = '0, mem_rdata_i = '0;
    logic [4:0]  rsd_i = '0;
    logic [2:0]  Op_i = '0;
    logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, mem_ack_i = 1'b0;
    logic        stall_o, mem_req_o, mem_we_o, valid_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, alu_result_o, memory_data_o;
    logic [4:0]  rsd_o;
    logic [2:0]  Op_o;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] md;
        logic [4:0]  rsd;
        logic [2:0]  op;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .alu_result_i(alu_result_i), .wdata_i(wdata_i),
        .rsd_i(rsd_i), .Op_i(Op_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .alu_result_o(alu_result_o),
        .memory_data_o(memory_data_o), .rsd_o(rsd_o), .Op_o(Op_o), .valid_o(valid_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rsd,
                        input logic [2:0] op);
        exp_t e;
        e.alu = alu; e.md = md; e.rsd = rsd; e.op = op;
        sb.push_back(e);
    endtask

    // every valid_o sample consumes the oldest expected result
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("alu_result", alu_result_o, e.alu);
                chk("memory_data", memory_data_o, e.md);
                chk("rsd", 32'(rsd_o), 32'(e.rsd));
                chk("op", 32'(Op_o), 32'(e.op));
            end
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rsd, input logic [2:0] op);
        valid_i = v; mem_read_i = rd; mem_write_i = wr;
        alu_result_i = alu; wdata_i = wd; rsd_i = rsd; Op_i = op;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_alu"}, alu_result_o, 32'd0);
        chk({tag, "_md"}, memory_data_o, 32'd0);
        chk({tag, "_rsd"}, 32'(rsd_o), 32'd0);
        chk({tag, "_op"}, 32'(Op_o), 32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        rst_i = 1'b0;

        // ALU-only instruction
        drive(1, 0, 0, 32'h10, 32'h0, 5'd5, 3'b010);
        push(32'h10, 32'h0, 5'd5, 3'b010);
        chk("alu_stall", 32'(stall_o), 32'd0);
        tick();
        chk("alu_valid", 32'(valid_o), 32'd1);
        chk("alu_stall_after", 32'(stall_o), 32'd0);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        tick();
        chk("alu_bubble", 32'(valid_o), 32'd0);

        // load, ack in the third WAIT cycle
        drive(1, 1, 0, 32'h100, 32'h0, 5'd7, 3'b001);
        push(32'h100, 32'hDEADBEEF, 5'd7, 3'b001);
        tick();
        drive(0, 0, 0, 32'hBAD0BAD0, 32'h0, 5'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(stall_o), 32'd1);
            chk("ld_req", 32'(mem_req_o), 32'd1);
            chk("ld_we", 32'(mem_we_o), 32'd0);
            chk("ld_addr", mem_addr_o, 32'h100);
            chk("ld_valid_wait", 32'(valid_o), 32'd0);
            if (i == 2) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'hDEADBEEF;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0;
        chk("ld_done_valid", 32'(valid_o), 32'd1);
        chk("ld_done_stall", 32'(stall_o), 32'd0);
        chk("ld_done_req", 32'(mem_req_o), 32'd0);
        chk("ld_done_addr", mem_addr_o, 32'd0);
        tick();
        chk("ld_single_pulse", 32'(valid_o), 32'd0);

        // store followed by an ALU op held upstream during WAIT
        drive(1, 0, 1, 32'h200, 32'h1234, 5'd9, 3'b011);
        push(32'h200, 32'h0, 5'd9, 3'b011);
        tick();
        drive(1, 0, 0, 32'h55, 32'h0, 5'd10, 3'b100);
        push(32'h55, 32'h0, 5'd10, 3'b100);
        for (int i = 0; i < 2; i++) begin
            chk("st_stall", 32'(stall_o), 32'd1);
            chk("st_req", 32'(mem_req_o), 32'd1);
            chk("st_we", 32'(mem_we_o), 32'd1);
            chk("st_addr", mem_addr_o, 32'h200);
            chk("st_wdata", mem_wdata_o, 32'h1234);
            if (i == 1) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'hFFFFFFFF;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        chk("st_done_valid", 32'(valid_o), 32'd1);
        chk("st_next_stall", 32'(stall_o), 32'd0);
        tick();
        chk("held_alu_valid", 32'(valid_o), 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        tick();
        chk("held_alu_once", 32'(valid_o), 32'd0);

        // ack while IDLE is ignored
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_ack_i = 1'b0;
        chk("idle_ack_valid", 32'(valid_o), 32'd0);
        chk("idle_ack_req", 32'(mem_req_o), 32'd0);

        // reset in the second WAIT cycle, late ack afterwards
        drive(1, 1, 0, 32'h300, 32'h0, 5'd3, 3'b101);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        tick();
        chk("rst_wait_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_zero("midwait_rst");
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h77777777;
        tick();
        mem_ack_i = 1'b0;
        chk("late_ack_valid", 32'(valid_o), 32'd0);
        chk("late_ack_stall", 32'(stall_o), 32'd0);
        tick();
        chk("late_ack_valid2", 32'(valid_o), 32'd0);

        // ALU op after reset
        drive(1, 0, 0, 32'hA5A5A5A5, 32'h0, 5'd31, 3'b111);
        push(32'hA5A5A5A5, 32'h0, 5'd31, 3'b111);
        tick();
        chk("post_rst_alu_valid", 32'(valid_o), 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        tick();

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after four WAIT cycles
        drive(1, 1, 0, 32'h400, 32'h0, 5'd4, 3'b001);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", 32'(stall_o), 32'd1);
            chk("to_err_pending", 32'(err_o), 32'd0);
            tick();
        end
        chk("to_stall_done", 32'(stall_o), 32'd0);
        chk("to_req_done", 32'(mem_req_o), 32'd0);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_valid", 32'(valid_o), 32'd0);
        drive(1, 0, 0, 32'h66, 32'h0, 5'd6, 3'b110);
        push(32'h66, 32'h0, 5'd6, 3'b110);
        tick();
        chk("to_alu_valid", 32'(valid_o), 32'd1);
        chk("to_err_sticky", 32'(err_o), 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("to_err_cleared", 32'(err_o), 32'd0);
        // ack on the fourth WAIT cycle wins over the limit
        drive(1, 1, 0, 32'h404, 32'h0, 5'd8, 3'b010);
        push(32'h404, 32'hCAFEF00D, 5'd8, 3'b010);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'hCAFEF00D;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        chk("edge_ack_valid", 32'(valid_o), 32'd1);
        chk("edge_ack_err", 32'(err_o), 32'd0);
`else
        // without the timeout the access waits indefinitely
        drive(1, 1, 0, 32'h400, 32'h0, 5'd4, 3'b001);
        push(32'h400, 32'h13572468, 5'd4, 3'b001);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            chk("long_stall", 32'(stall_o), 32'd1);
            chk("long_err", 32'(err_o), 32'd0);
            if (i == 7) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h13572468;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        chk("long_valid", 32'(valid_o), 32'd1);
        chk("long_err_done", 32'(err_o), 32'd0);
`endif
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
